// File: rtl/io_tx_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_tx_bridge_pkg
// Description : Shared IO addresses, stop-FSM encoding and helpers for the
//               CPU-to-UART transmit bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package io_tx_bridge_pkg;

    localparam logic [1:0]  c_io_region    = 2'b11;
    localparam logic [17:0] c_addr_tx_data = 18'h30000;
    localparam logic [17:0] c_addr_stop    = 18'h30004;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TERM  = 2'd2,
        ST_DONE  = 2'd3
    } stop_state_t;

    function automatic logic [7:0] snapshot_byte(input logic [31:0] snap,
                                                 input logic [1:0]  sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = snap[7:0];
            2'd1:    b = snap[15:8];
            2'd2:    b = snap[23:16];
            default: b = snap[31:24];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo
// Description : First-word fall-through FIFO; head entry is visible on o_head
//               whenever the FIFO is non-empty. Pushes into a full FIFO are
//               dropped unless a pop frees a slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);

    localparam int                 c_ptr_w      = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full_count = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_count);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_drop  = i_push && !w_do_push;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_tx_bridge.sv
`default_nettype none
// ============================================================================
// Module      : io_tx_bridge
// Description : Memory-mapped CPU bridge feeding a UART transmitter, with a
//               cycle-counter snapshot port and a stop/drain/terminate FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module io_tx_bridge
    import io_tx_bridge_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  io_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_done,
    output logic        overflow
);

    localparam int                c_cnt_w      = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_level = c_cnt_w'(DEPTH - FULL_MARGIN);

    stop_state_t r_state;
    logic [31:0] r_cycle;
    logic [31:0] r_snapshot;
    logic [7:0]  r_io_din;
    logic        r_buffer_full;
    logic        r_program_done;
    logic        r_overflow;

    logic [17:0]        w_addr;
    logic               w_io_sel;
    logic               w_rd;
    logic               w_wr_stop;
    logic               w_push;
    logic               w_term_pop;
    logic               w_count_high;
    logic [7:0]         w_fifo_head;
    logic               w_fifo_empty;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic               w_fifo_drop;
    logic               w_unused_addr;

    assign w_addr        = mem_a[17:0];
    assign w_unused_addr = ^mem_a[31:18];
    assign w_io_sel      = rdy_in && (w_addr[17:16] == c_io_region);
    assign w_rd          = w_io_sel && !mem_wr;

    // Once a stop is requested every subsequent CPU write is ignored.
    assign w_wr_stop  = w_io_sel && mem_wr && (w_addr == c_addr_stop) && (r_state == ST_RUN);
    assign w_push     = w_io_sel && mem_wr && (w_addr == c_addr_tx_data)
                        && (mem_dout != 8'h00) && (r_state == ST_RUN);
    assign w_term_pop = (r_state == ST_TERM) && tx_ready;
    assign w_count_high = (w_fifo_count >= c_full_level);

    io_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk_in),
        .rst         (rst_in),
        .i_push      (w_push),
        .i_push_data (mem_dout),
        .i_pop       (tx_ready),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count),
        .o_drop      (w_fifo_drop)
    );

    // In TERM the FIFO is empty, so the gated head yields the 0x00 terminator.
    assign tx_valid       = !w_fifo_empty || (r_state == ST_TERM);
    assign tx_data        = w_fifo_empty ? 8'h00 : w_fifo_head;
    assign io_din         = r_io_din;
    assign io_buffer_full = r_buffer_full;
    assign program_done   = r_program_done;
    assign overflow       = r_overflow;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cycle    <= '0;
            r_snapshot <= '0;
            r_io_din   <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_rd) begin
                case (w_addr)
                    c_addr_stop: begin
                        r_snapshot <= r_cycle;
                        r_io_din   <= r_cycle[7:0];
                    end
                    c_addr_stop + 18'd1: r_io_din <= snapshot_byte(r_snapshot, 2'd1);
                    c_addr_stop + 18'd2: r_io_din <= snapshot_byte(r_snapshot, 2'd2);
                    c_addr_stop + 18'd3: r_io_din <= snapshot_byte(r_snapshot, 2'd3);
                    default:             r_io_din <= 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= ST_RUN;
            r_buffer_full  <= 1'b0;
            r_program_done <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN:   if (w_wr_stop)    r_state <= ST_DRAIN;
                ST_DRAIN: if (w_fifo_empty) r_state <= ST_TERM;
                ST_TERM:  if (w_term_pop)   r_state <= ST_DONE;
                default:                    r_state <= ST_DONE;
            endcase
            // Follows the next state so the CPU is throttled from the stop onward.
            r_buffer_full <= w_count_high
                             || w_wr_stop
                             || (r_state == ST_DRAIN)
                             || ((r_state == ST_TERM) && !w_term_pop);
            if (w_term_pop) begin
                r_program_done <= 1'b1;
            end
            if (w_fifo_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_tx_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_tx_bridge
// Description : Directed self-checking bench for io_tx_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_tx_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  io_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_done;
    logic        overflow;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  q_out[$];

    io_tx_bridge #(
        .DEPTH       (16),
        .FULL_MARGIN (2)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .io_din         (io_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .program_done   (program_done),
        .overflow       (overflow)
    );

    always #5 clk_in = ~clk_in;

    // Bytes accepted by the UART, captured mid-cycle where inputs are settled.
    always @(negedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) begin
            q_out.push_back(tx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        mem_wr = 1'b0;
        mem_a  = '0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [7:0] data);
        mem_a    = addr;
        mem_dout = data;
        mem_wr   = 1'b1;
        @(posedge clk_in);
        #1;
        mem_wr   = 1'b0;
        mem_a    = '0;
    endtask

    task automatic cpu_read(input logic [31:0] addr, output logic [7:0] d);
        mem_a  = addr;
        mem_wr = 1'b0;
        @(posedge clk_in);
        #1;
        mem_a  = '0;
        d      = io_din;
    endtask

    initial begin
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] snap;

        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        tx_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_io_din",       32'(io_din),         32'h0);
        check("rst_tx_valid",     32'(tx_valid),       32'h0);
        check("rst_tx_data",      32'(tx_data),        32'h0);
        check("rst_buffer_full",  32'(io_buffer_full), 32'h0);
        check("rst_program_done", 32'(program_done),   32'h0);
        check("rst_overflow",     32'(overflow),       32'h0);

        // Three bytes streamed out in order with the UART always ready
        tx_ready = 1'b1;
        cpu_write(32'h0003_0000, 8'h41);
        cpu_write(32'h0003_0000, 8'h42);
        cpu_write(32'h0003_0000, 8'h43);
        idle(3);
        check("abc_count", 32'(q_out.size()), 32'd3);
        check("abc_0", 32'(q_out[0]), 32'h41);
        check("abc_1", 32'(q_out[1]), 32'h42);
        check("abc_2", 32'(q_out[2]), 32'h43);
        check("abc_idle_valid", 32'(tx_valid), 32'h0);

        // Writes that must not push: zero data, rdy low, outside IO region, other IO address
        q_out.delete();
        tx_ready = 1'b0;
        cpu_write(32'h0003_0000, 8'h00);
        check("zero_valid", 32'(tx_valid), 32'h0);
        rdy_in = 1'b0;
        cpu_write(32'h0003_0000, 8'h5A);
        rdy_in = 1'b1;
        check("rdy_low_valid", 32'(tx_valid), 32'h0);
        cpu_write(32'h0001_0000, 8'h59);
        check("non_io_valid", 32'(tx_valid), 32'h0);
        cpu_write(32'h0003_0001, 8'h57);
        check("other_io_valid", 32'(tx_valid), 32'h0);

        // Fill threshold and overflow
        do_reset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 14; i++) cpu_write(32'h0003_0000, 8'(i));
        check("full_lag", 32'(io_buffer_full), 32'h0);
        check("fifo_head_hold", 32'(tx_data), 32'h01);
        idle(1);
        check("full_at_14", 32'(io_buffer_full), 32'h1);
        cpu_write(32'h0003_0000, 8'd15);
        cpu_write(32'h0003_0000, 8'd16);
        check("no_ovf_at_16", 32'(overflow), 32'h0);
        cpu_write(32'h0003_0000, 8'd17);
        check("ovf_at_17", 32'(overflow), 32'h1);
        q_out.delete();
        tx_ready = 1'b1;
        idle(20);
        tx_ready = 1'b0;
        check("ovf_drain_count", 32'(q_out.size()), 32'd16);
        check("ovf_drain_first", 32'(q_out[0]), 32'd1);
        check("ovf_drain_last", 32'(q_out[15]), 32'd16);
        check("ovf_drain_full", 32'(io_buffer_full), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Push and pop together while full
        do_reset();
        for (int i = 0; i < 16; i++) cpu_write(32'h0003_0000, 8'(8'h20 + i));
        q_out.delete();
        tx_ready = 1'b1;
        cpu_write(32'h0003_0000, 8'h99);
        tx_ready = 1'b0;
        check("pp_no_ovf", 32'(overflow), 32'h0);
        check("pp_full_held", 32'(io_buffer_full), 32'h1);
        check("pp_popped", 32'(q_out[0]), 32'h20);
        check("pp_new_head", 32'(tx_data), 32'h21);
        tx_ready = 1'b1;
        idle(20);
        tx_ready = 1'b0;
        check("pp_total", 32'(q_out.size()), 32'd17);
        check("pp_last_old", 32'(q_out[15]), 32'h2F);
        check("pp_last_new", 32'(q_out[16]), 32'h99);

        // Cycle counter snapshot at cycle 100 and cycle 300
        do_reset();
        idle(100);
        cpu_read(32'h0003_0004, b0);
        cpu_read(32'h0003_0005, b1);
        cpu_read(32'h0003_0006, b2);
        cpu_read(32'h0003_0007, b3);
        snap = {b3, b2, b1, b0};
        check("snap100", snap, 32'd100);
        cpu_read(32'h0003_0000, b0);
        check("read_data_addr", 32'(b0), 32'h0);
        rdy_in = 1'b0;
        idle(195);
        rdy_in = 1'b1;
        cpu_read(32'h0003_0004, b0);
        cpu_read(32'h0003_0005, b1);
        cpu_read(32'h0003_0006, b2);
        cpu_read(32'h0003_0007, b3);
        check("snap300_b0", 32'(b0), 32'h2C);
        check("snap300_b1", 32'(b1), 32'h01);
        check("snap300", {b3, b2, b1, b0}, 32'd300);

        // Stop sequence with toggling ready
        do_reset();
        tx_ready = 1'b0;
        cpu_write(32'h0003_0000, 8'h51);
        cpu_write(32'h0003_0000, 8'h52);
        cpu_write(32'h0003_0000, 8'h53);
        cpu_write(32'h0003_0004, 8'h01);
        check("stop_full", 32'(io_buffer_full), 32'h1);
        cpu_write(32'h0003_0000, 8'h77);
        q_out.delete();
        for (int i = 0; i < 40 && !program_done; i++) begin
            tx_ready = (i % 2) == 1;
            idle(1);
        end
        tx_ready = 1'b0;
        check("stop_done", 32'(program_done), 32'h1);
        check("stop_count", 32'(q_out.size()), 32'd4);
        check("stop_b0", 32'(q_out[0]), 32'h51);
        check("stop_b1", 32'(q_out[1]), 32'h52);
        check("stop_b2", 32'(q_out[2]), 32'h53);
        check("stop_term", 32'(q_out[3]), 32'h00);
        check("done_valid", 32'(tx_valid), 32'h0);
        cpu_write(32'h0003_0000, 8'h58);
        idle(1);
        check("done_ignore_wr", 32'(tx_valid), 32'h0);
        check("done_sticky", 32'(program_done), 32'h1);

        // Reset in the middle of draining
        do_reset();
        cpu_write(32'h0003_0000, 8'h61);
        cpu_write(32'h0003_0000, 8'h62);
        cpu_write(32'h0003_0000, 8'h63);
        cpu_write(32'h0003_0004, 8'h01);
        tx_ready = 1'b1;
        idle(1);
        rdy_in = 1'b0;
        rst_in = 1'b1;
        idle(1);
        check("mid_rst_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_data", 32'(tx_data), 32'h0);
        check("mid_rst_full", 32'(io_buffer_full), 32'h0);
        check("mid_rst_done", 32'(program_done), 32'h0);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        idle(5);
        check("post_rst_valid", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;
        cpu_write(32'h0003_0000, 8'h6A);
        check("post_rst_push_valid", 32'(tx_valid), 32'h1);
        check("post_rst_push_data", 32'(tx_data), 32'h6A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
